// File: rtl/disp_pkg.sv
// Shared constants and types for the measurement display scheduler.
// ASCII glyphs, per-line suffixes, FSM encoding and parameter defaults.
package disp_pkg;

    localparam logic [7:0] A_SP   = 8'h20;
    localparam logic [7:0] A_US   = 8'h5F;
    localparam logic [7:0] A_0    = 8'h30;
    localparam logic [7:0] A_QM   = 8'h3F;
    localparam logic [7:0] A_DASH = 8'h2D;

    localparam logic [3:0][31:0] SUFFIX = {"    ", "%   ", "us  ", "Hz  "};

    localparam logic [127:0] LINE_OVF = {A_SP, A_SP, "OVERFLOW", {6{A_SP}}};
    localparam logic [127:0] LINE_TMO = {A_SP, A_SP, {8{A_DASH}}, {6{A_SP}}};

    localparam int unsigned DEF_MAX_VAL     = 99999999;
    localparam int unsigned DEF_CVT_TIMEOUT = 256;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPTURE,
        S_START,
        S_WAIT,
        S_FORMAT,
        S_EMIT
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first request at or after ptr.
// Returns one-hot grant, its index and an any-grant flag.
module rr_arbiter #(
    parameter int unsigned N_REQ = 3
) (
    input  logic [N_REQ-1:0] req,
    input  logic [1:0]       ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [1:0]       gnt_idx,
    output logic             gnt_any
);

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int off = 0; off < N_REQ; off++) begin
            for (int k = 0; k < N_REQ; k++) begin
                if (!gnt_any && req[k] &&
                    k == (int'(ptr) + off) % N_REQ) begin
                    gnt[k]  = 1'b1;
                    gnt_idx = 2'(k);
                    gnt_any = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/disp_conv_sched.sv
// Shares one binary-to-BCD converter among measurement sources and
// formats each result as a 16-char ASCII line for the OLED engine.
module disp_conv_sched
    import disp_pkg::*;
#(
    parameter int unsigned N_REQ       = 3,
    parameter int unsigned CVT_TIMEOUT = DEF_CVT_TIMEOUT,
    parameter int unsigned MAX_VAL     = DEF_MAX_VAL,
    parameter int unsigned BLANK_LZ    = 1
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [32*N_REQ-1:0]   req_value,
    output logic [N_REQ-1:0]      req_ready,
    output logic                  cvt_start,
    output logic [31:0]           cvt_bin,
    input  logic                  cvt_done,
    input  logic [31:0]           cvt_bcd,
    output logic [127:0]          line_char,
    output logic [1:0]            line_idx,
    output logic                  line_valid,
    input  logic                  line_ready,
    output logic                  err_timeout
);

    localparam int CW = $clog2(CVT_TIMEOUT + 1);

    state_e             state_q, state_d;
    logic [1:0]         ptr_q, gnt_q, idx_q;
    logic [N_REQ-1:0]   gnt_oh_q;
    logic [31:0]        val_q, bcd_q, cap_val;
    logic               ovf_q, tmo_q, err_q, cap_ovf, tmo_hit;
    logic [CW-1:0]      cnt_q;
    logic [127:0]       line_q;
    logic [N_REQ-1:0]   arb_gnt;
    logic [1:0]         arb_idx;
    logic               arb_any;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req     (req_valid),
        .ptr     (ptr_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .gnt_any (arb_any)
    );

    // Leading zeros blank until the first nonzero or illegal digit.
    function automatic logic [127:0] fmt_normal(
        input logic [31:0] bcd,
        input logic [1:0]  idx
    );
        logic [7:0][7:0] ch;
        logic            lead;
        logic [3:0]      d;
        logic [7:0]      s_hi, s_lo;
        lead = 1'b1;
        for (int k = 7; k >= 0; k--) begin
            d = bcd[4*k +: 4];
            if (d > 4'd9) begin
                ch[k] = A_QM;
                lead  = 1'b0;
            end else if (lead && d == 4'd0 && k != 0 && BLANK_LZ != 0) begin
                ch[k] = A_SP;
            end else begin
                ch[k] = A_0 | {4'h0, d};
                lead  = 1'b0;
            end
        end
        s_hi = (ch[6] == A_SP) ? A_SP : A_US;
        s_lo = (ch[3] == A_SP) ? A_SP : A_US;
        return {A_SP, A_SP, ch[7], ch[6], s_hi, ch[5], ch[4], ch[3],
                s_lo, ch[2], ch[1], ch[0], SUFFIX[idx]};
    endfunction

    always_comb begin
        cap_val = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_q == 2'(i)) cap_val = req_value[32*i +: 32];
        end
    end

    assign cap_ovf = cap_val > 32'(MAX_VAL);
    assign tmo_hit = cnt_q == CW'(CVT_TIMEOUT);

    always_comb begin
        state_d    = state_q;
        req_ready  = '0;
        cvt_start  = 1'b0;
        line_valid = 1'b0;
        unique case (state_q)
            S_IDLE:    if (arb_any) state_d = S_CAPTURE;
            S_CAPTURE: begin
                req_ready = gnt_oh_q;
                state_d   = cap_ovf ? S_FORMAT : S_START;
            end
            S_START: begin
                cvt_start = 1'b1;
                state_d   = S_WAIT;
            end
            S_WAIT:    if (cvt_done || tmo_hit) state_d = S_FORMAT;
            S_FORMAT:  state_d = S_EMIT;
            S_EMIT: begin
                line_valid = 1'b1;
                if (line_ready) state_d = S_IDLE;
            end
            default:   state_d = S_IDLE;
        endcase
        if (sys_rst) begin
            req_ready  = '0;
            cvt_start  = 1'b0;
            line_valid = 1'b0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q  <= S_IDLE;
            ptr_q    <= '0;
            gnt_q    <= '0;
            gnt_oh_q <= '0;
            idx_q    <= '0;
            val_q    <= '0;
            bcd_q    <= '0;
            ovf_q    <= 1'b0;
            tmo_q    <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            line_q   <= '0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                S_IDLE: if (arb_any) begin
                    gnt_q    <= arb_idx;
                    gnt_oh_q <= arb_gnt;
                end
                S_CAPTURE: begin
                    val_q <= cap_val;
                    idx_q <= gnt_q;
                    ovf_q <= cap_ovf;
                    tmo_q <= 1'b0;
                    ptr_q <= (gnt_q == 2'(N_REQ - 1)) ? 2'd0 : gnt_q + 2'd1;
                end
                S_START: cnt_q <= '0;
                S_WAIT: begin
                    if (cvt_done) begin
                        bcd_q <= cvt_bcd;
                    end else if (tmo_hit) begin
                        tmo_q <= 1'b1;
                        err_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_FORMAT: begin
                    if (ovf_q)      line_q <= LINE_OVF;
                    else if (tmo_q) line_q <= LINE_TMO;
                    else            line_q <= fmt_normal(bcd_q, idx_q);
                end
                default: ;
            endcase
        end
    end

    assign cvt_bin     = val_q;
    assign line_char   = line_q;
    assign line_idx    = idx_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_disp_conv_sched.sv
// Scoreboard bench for disp_conv_sched with a behavioural BCD converter.
// Expected lines are queued at stimulus time and popped on each accept.
module tb_disp_conv_sched;

    typedef struct {
        logic [1:0]   idx;
        logic [127:0] chr;
    } exp_t;

    localparam logic [127:0] L_12M = "  12_345_678Hz  ";
    localparam logic [127:0] L_1K  = "       1_000us  ";
    localparam logic [127:0] L_0US = "           0us  ";
    localparam logic [127:0] L_99M = "  99_999_999Hz  ";
    localparam logic [127:0] L_OVF = "  OVERFLOW      ";
    localparam logic [127:0] L_TMO = "  --------      ";
    localparam logic [127:0] L_QHI = "  ?0_000_005Hz  ";
    localparam logic [127:0] L_QLO = "           ?Hz  ";

    logic         sys_clk = 1'b0;
    logic         sys_rst;
    logic [2:0]   req_valid;
    logic [95:0]  req_value;
    logic [2:0]   req_ready;
    logic         cvt_start;
    logic [31:0]  cvt_bin;
    logic         cvt_done;
    logic [31:0]  cvt_bcd;
    logic [127:0] line_char;
    logic [1:0]   line_idx;
    logic         line_valid;
    logic         line_ready;
    logic         err_timeout;

    int checks   = 0;
    int failures = 0;
    int n_start  = 0;
    exp_t       exp_q[$];
    logic [2:0] gnt_log[$];

    int          stub_delay = 5;
    bit          stub_mute  = 0;
    logic [31:0] stub_or    = '0;
    int          force_req  = 0;

    disp_conv_sched dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .req_valid   (req_valid),
        .req_value   (req_value),
        .req_ready   (req_ready),
        .cvt_start   (cvt_start),
        .cvt_bin     (cvt_bin),
        .cvt_done    (cvt_done),
        .cvt_bcd     (cvt_bcd),
        .line_char   (line_char),
        .line_idx    (line_idx),
        .line_valid  (line_valid),
        .line_ready  (line_ready),
        .err_timeout (err_timeout)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] to_bcd(input logic [31:0] v);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            r[4*k +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic [127:0] model_line(input int idx,
                                                input logic [31:0] v);
        string s, d, sfx, u1, u2;
        logic [127:0] r;
        if (v > 32'd99999999) begin
            s = "  OVERFLOW      ";
        end else begin
            d = $sformatf("%8d", v);
            case (idx)
                0:       sfx = "Hz  ";
                1:       sfx = "us  ";
                2:       sfx = "%   ";
                default: sfx = "    ";
            endcase
            u1 = (d[1] == 8'h20) ? " " : "_";
            u2 = (d[4] == 8'h20) ? " " : "_";
            s = {"  ", d.substr(0, 1), u1, d.substr(2, 4), u2,
                 d.substr(5, 7), sfx};
        end
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = s[i];
        return r;
    endfunction

    // Behavioural converter: answers stub_delay cycles after cvt_start.
    initial begin
        int          stub_cnt;
        int          force_ack;
        logic [31:0] stub_bcd;
        stub_cnt  = 0;
        force_ack = 0;
        stub_bcd  = '0;
        cvt_done  = 1'b0;
        cvt_bcd   = '0;
        forever begin
            @(posedge sys_clk);
            #1;
            cvt_done = 1'b0;
            if (sys_rst) begin
                stub_cnt = 0;
            end else begin
                if (force_req != force_ack) begin
                    force_ack = force_req;
                    cvt_done  = 1'b1;
                    cvt_bcd   = 32'h1111_1111;
                end
                if (stub_cnt > 0) begin
                    stub_cnt--;
                    if (stub_cnt == 0) begin
                        cvt_done = 1'b1;
                        cvt_bcd  = stub_bcd;
                    end
                end
                if (cvt_start && !stub_mute) begin
                    stub_bcd = to_bcd(cvt_bin) | stub_or;
                    stub_cnt = stub_delay;
                end
            end
        end
    end

    always @(negedge sys_clk) begin
        exp_t e;
        if (line_valid && line_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected", 128'(exp_q.size()), 128'd1);
            end else begin
                e = exp_q.pop_front();
                check("line_char", line_char, e.chr);
                check("line_idx", 128'(line_idx), 128'(e.idx));
            end
        end
        if (|req_ready) gnt_log.push_back(req_ready);
        if (cvt_start) n_start++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic tick();
        @(posedge sys_clk);
        #2;
    endtask

    task automatic grant(input int idx, input logic [31:0] val);
        bit got;
        got = 0;
        req_value[32*idx +: 32] = val;
        req_valid[idx] = 1'b1;
        for (int n = 0; n < 50 && !got; n++) begin
            tick();
            got = req_ready[idx];
        end
        req_valid[idx] = 1'b0;
        check("grant_wait", 128'(got), 128'd1);
    endtask

    task automatic drain(input int budget);
        bit ok;
        ok = 0;
        for (int n = 0; n < budget && !ok; n++) begin
            tick();
            ok = (exp_q.size() == 0) && !line_valid;
        end
        check("drain", 128'(ok), 128'd1);
    endtask

    task automatic serve(input int idx, input logic [31:0] val,
                         input logic [127:0] exp);
        exp_q.push_back('{2'(idx), exp});
        grant(idx, val);
        drain(600);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ready"}, 128'(req_ready), 128'd0);
        check({tag, "_start"}, 128'(cvt_start), 128'd0);
        check({tag, "_valid"}, 128'(line_valid), 128'd0);
        check({tag, "_char"}, line_char, 128'd0);
        check({tag, "_idx"}, 128'(line_idx), 128'd0);
        check({tag, "_err"}, 128'(err_timeout), 128'd0);
    endtask

    initial begin
        bit          got;
        int          ns, ng;
        logic [31:0] v;
        logic [2:0]  rr_exp[6];

        sys_rst    = 1'b1;
        req_valid  = '0;
        req_value  = '0;
        line_ready = 1'b0;
        tick();
        tick();
        check_zero("rst");
        sys_rst = 1'b0;
        tick();
        check("idle_valid", 128'(line_valid), 128'd0);

        // single request, latency and hold while not ready
        stub_delay = 40;
        req_value[31:0] = 32'd12345678;
        req_valid = 3'b001;
        tick();
        check("t1_ready", 128'(req_ready), 128'b001);
        req_valid = 3'b000;
        tick();
        check("t1_start", 128'(cvt_start), 128'd1);
        check("t1_bin", 128'(cvt_bin), 128'd12345678);
        got = 0;
        for (int n = 0; n < 80 && !got; n++) begin
            tick();
            got = cvt_done;
        end
        check("t1_done_wait", 128'(got), 128'd1);
        tick();
        check("t1_lv_early", 128'(line_valid), 128'd0);
        tick();
        check("t1_lv", 128'(line_valid), 128'd1);
        repeat (5) tick();
        check("t1_hold_lv", 128'(line_valid), 128'd1);
        check("t1_hold_char", line_char, L_12M);
        check("t1_hold_idx", 128'(line_idx), 128'd0);
        exp_q.push_back('{2'd0, L_12M});
        line_ready = 1'b1;
        tick();
        check("t1_lv_drop", 128'(line_valid), 128'd0);
        check("t1_sb", 128'(exp_q.size()), 128'd0);

        // blanking, max value, random values
        stub_delay = 5;
        serve(1, 32'd1000, L_1K);
        serve(1, 32'd0, L_0US);
        serve(0, 32'd99999999, L_99M);
        for (int i = 0; i < 4; i++) begin
            v = 32'($urandom_range(0, 99999999));
            serve(i % 3, v, model_line(i % 3, v));
        end

        // overflow bypasses the converter
        ns = n_start;
        serve(0, 32'd100000000, L_OVF);
        serve(2, 32'hFFFF_FFFF, L_OVF);
        check("ovf_nostart", 128'(n_start - ns), 128'd0);

        // illegal BCD digits
        stub_or = 32'hC000_0000;
        serve(0, 32'd5, L_QHI);
        stub_or = 32'h0000_000A;
        serve(0, 32'd0, L_QLO);
        stub_or = '0;

        // converter timeout, late done ignored, sticky error
        check("tmo_err_pre", 128'(err_timeout), 128'd0);
        stub_mute = 1;
        exp_q.push_back('{2'd0, L_TMO});
        grant(0, 32'd5);
        drain(400);
        check("tmo_err", 128'(err_timeout), 128'd1);
        force_req++;
        tick();
        tick();
        check("late_done_lv", 128'(line_valid), 128'd0);
        stub_mute = 0;
        serve(1, 32'd77, model_line(1, 32'd77));
        check("tmo_sticky", 128'(err_timeout), 128'd1);

        // round robin from a fresh pointer
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        check("rr_rst_err", 128'(err_timeout), 128'd0);
        gnt_log.delete();
        req_value = {32'd7, 32'd42, 32'd5000000};
        for (int r = 0; r < 2; r++) begin
            exp_q.push_back('{2'd0, model_line(0, 32'd5000000)});
            exp_q.push_back('{2'd1, model_line(1, 32'd42)});
            exp_q.push_back('{2'd2, model_line(2, 32'd7)});
        end
        rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        req_valid = 3'b111;
        ng = 0;
        for (int n = 0; n < 400 && ng < 6; n++) begin
            tick();
            if (|req_ready) ng++;
        end
        req_valid = 3'b000;
        check("rr_grants", 128'(ng), 128'd6);
        drain(200);
        check("rr_log_n", 128'(gnt_log.size()), 128'd6);
        for (int i = 0; i < 6 && i < gnt_log.size(); i++)
            check($sformatf("rr_gnt%0d", i), 128'(gnt_log[i]), 128'(rr_exp[i]));

        // reset while waiting on the converter
        stub_delay = 50;
        grant(2, 32'd123);
        repeat (10) tick();
        sys_rst = 1'b1;
        tick();
        check_zero("rw");
        sys_rst = 1'b0;
        repeat (60) tick();
        check("rw_quiet", 128'(line_valid), 128'd0);

        // reset while a line waits for acceptance
        stub_delay = 5;
        line_ready = 1'b0;
        grant(1, 32'd9);
        got = 0;
        for (int n = 0; n < 50 && !got; n++) begin
            tick();
            got = line_valid;
        end
        check("re_lv_wait", 128'(got), 128'd1);
        sys_rst = 1'b1;
        tick();
        check_zero("re");
        sys_rst = 1'b0;
        tick();
        check("re_dropped", 128'(line_valid), 128'd0);

        // pointer back at requester 0
        line_ready = 1'b1;
        req_value = {32'd33, 32'd22, 32'd11};
        exp_q.push_back('{2'd0, model_line(0, 32'd11)});
        req_valid = 3'b111;
        got = 0;
        for (int n = 0; n < 20 && !got; n++) begin
            tick();
            got = |req_ready;
        end
        check("prio_ready", 128'(req_ready), 128'b001);
        req_valid = 3'b000;
        drain(100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/disp_conv_sched.md
Name: disp_conv_sched

Overview:
- Shares one sequential binary-to-BCD converter between N_REQ measurement sources: frequency, period and duty.
- Round-robin arbitration; sequences the converter via start/done handshake.
- Formats each result into a 16-character ASCII line for the OLED text engine; delivers it with a valid/ready handshake tagged by line index.
- Sits between the measurement counters and the OLED line buffer.

Parameters:
- N_REQ, 3, number of requesters; also the number of OLED lines, max 4.
- CVT_TIMEOUT, 256, cycles allowed from cvt_start to cvt_done before abort.
- MAX_VAL, 99999999, largest displayable value; larger values show an overflow line.
- BLANK_LZ, 1, 1 = leading zero digits become spaces (least significant digit always shown).

Ports:
- sys_clk  in  1  system clock
- sys_rst  in  1  reset, synchronous, active-high
- req_valid  in  N_REQ  requester i has a value pending
- req_value  in  32*N_REQ  value of requester i, bits [32i+31:32i], unsigned
- req_ready  out  N_REQ  one-cycle pulse: requester i's value captured
- cvt_start  out  1  one-cycle pulse: converter begins on cvt_bin
- cvt_bin  out  32  operand to converter
- cvt_done  in  1  one-cycle pulse: cvt_bcd valid
- cvt_bcd  in  32  8 BCD digits, [31:28] most significant
- line_char  out  128  16 ASCII chars, [127:120] leftmost
- line_idx  out  2  OLED line number = requester index
- line_valid  out  1  line_char/line_idx valid; held until accepted
- line_ready  in  1  OLED engine accepts when line_valid & line_ready
- err_timeout  out  1  sticky; set on converter timeout, cleared only by reset

Behaviour:
- Reset: all outputs 0; state IDLE; round-robin pointer 0 (requester 0 highest priority); capture registers 0.
- Reset asserted in any state returns to IDLE next edge. No pulse outputs fire in the reset cycle. A pending line is dropped.
- FSM states: IDLE, CAPTURE, START, WAIT, FORMAT, EMIT.
- IDLE:
  - If any req_valid, grant the first set bit at or after the pointer, wrapping modulo N_REQ.
  - Go to CAPTURE.
- CAPTURE:
  - Latch req_value[g] and g.
  - Pulse req_ready[g] for exactly one cycle.
  - Pointer <= (g+1) mod N_REQ.
  - If value > MAX_VAL, go to FORMAT with the overflow flag set; else go to START.
- START:
  - cvt_bin = latched value; cvt_start pulses for one cycle.
  - Clear the timeout counter; go to WAIT.
- WAIT:
  - On cvt_done, latch cvt_bcd and go to FORMAT.
  - A cvt_done in the same cycle the counter reaches CVT_TIMEOUT counts as success.
  - If CVT_TIMEOUT cycles elapse first, set err_timeout, mark the line as error and go to FORMAT.
  - A late cvt_done arriving in any other state is ignored.
- FORMAT: build line_char, one cycle; go to EMIT.
  - Normal line: "  D8D7_D6D5D4_D3D2D1" followed by a 4-character suffix.
  - Each digit is 0x30+bcd. Underscore is 0x5F.
  - Suffix by index: 0 "Hz  ", 1 "us  ", 2 "%   ", 3 "    ".
  - BLANK_LZ=1: leading zero digits become 0x20. An underscore separator is blanked when every digit to its left is blank.
  - Overflow line: "  OVERFLOW" + 6 spaces.
  - Timeout line: "  --------" + 6 spaces.
  - Bcd digits > 9 (illegal): that character shows '?' (0x3F).
- EMIT:
  - line_valid = 1 with line_char and line_idx stable.
  - Handshake completes when line_valid & line_ready are both high on an edge.
  - Next cycle: line_valid = 0, state IDLE.
  - line_ready high while line_valid is low has no effect.
- Latency: a req_valid rising in IDLE gives req_ready 1 cycle later and cvt_start 2 cycles later. line_valid rises 2 cycles after cvt_done.
- Fairness: a requester continuously valid is served at most once per N_REQ grants while others are pending.
- req_valid dropping before its grant cancels that request silently.

Decomposition:
- Shared package disp_pkg holds:
  - ASCII constants: space, underscore, '0', '?', '-'.
  - Suffix strings per line index.
  - State enum encoding.
  - Defaults for MAX_VAL and CVT_TIMEOUT.
- One sub-module, rr_arbiter (N_REQ request bits, pointer in, one-hot grant plus index out, combinational). The FSM, timeout counter and formatter stay in disp_conv_sched.

Test Plan:
- Single request: req_valid[0]=1, value 12345678, stub cvt_done after 40 cycles → req_ready[0] 1 cycle later; line_char "  12_345_678Hz  "; line_idx 0; line_valid holds until line_ready.
- Blanking: value 1000 on requester 1, BLANK_LZ=1 → "       1_000us  "; value 0 → "           0us  ".
- Round-robin: all three valid continuously, line_ready tied 1 → grants in order 0,1,2,0,1,2; pointer wraps.
- Overflow: value 100000000 on requester 0 → no cvt_start; line "  OVERFLOW      ".
- Timeout: stub never asserts cvt_done → after 256 cycles err_timeout=1 and line "  --------      "; a late cvt_done is then ignored and the next request converts normally.
- Reset mid-operation: assert sys_rst during WAIT and during EMIT with line_ready=0 → next edge all outputs 0; after release, requester 0 has priority again.
